pswd_auth_ctrl: RTL
===================

# pswd_auth_ctrl

Parametrised multi-user password authentication controller, the next generation of the project's fixed 6-digit, 4-bit-per-digit password checker. It collects a user-keyed password one digit per `EnterPswd` strobe and reads only the claimed user's entry from an external synchronous password ROM. It asserts `Authenticated` until logout and adds a lockout after repeated failures. It sits between the switch/button debounce logic and the game's session control.

## Interface
- `NUM_USERS`, default 8: number of valid user IDs, 0..NUM_USERS-1; must satisfy NUM_USERS ≤ 2^ID_W.
- `ID_W`, default 5: width of `InternalID` and `RomAddr`.
- `DIGITS`, default 6: number of password digits.
- `DIG_W`, default 4: bits per digit (4 = hex).
- `ROM_LAT`, default 2: ROM read latency in cycles, ≥ 1.
- `MAX_FAILS`, default 3: consecutive failed checks that trigger lockout, ≥ 1.
- `LOCK_CYCLES`, default 1024: lockout duration in cycles, ≥ 1.

Ports:
- `Clk`  in  1  single system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `BeginCheck`  in  1  start a check; acted on only in IDLE.
- `InternalID`  in  ID_W  claimed user ID; sampled on the BeginCheck cycle.
- `EnterPswd`  in  1  single-cycle strobe that accepts `InputSwitches` as the next digit.
- `InputSwitches`  in  DIG_W  digit value.
- `LogOutPulse`  in  1  logs out in PASSED; aborts entry in GET_DIG.
- `RomAddr`  out  ID_W  registered ROM address; equals the latched ID.
- `RomData`  in  DIGITS*DIG_W  ROM word; digit 0 is in the MSBs.
- `Authenticated`  out  1  high while in PASSED.
- `FailPulse`  out  1  one-cycle pulse per failed check.
- `LockedOut`  out  1  high while in LOCKED.
- `DigitCount`  out  clog2(DIGITS+1)  number of digits entered so far.

## Operation
- The FSM has six states: IDLE, GET_DIG, WAIT_ROM, COMPARE, PASSED, LOCKED.
- **IDLE:**
  - Clears the entry register, `DigitCount`, and the ROM-wait counter.
  - `BeginCheck`=1: latch `InternalID` into the ID register and `RomAddr`, then go to GET_DIG.
- **GET_DIG:**
  - Each cycle with `EnterPswd`=1 shifts `InputSwitches` into the entry register from the LSB side and increments `DigitCount`. The first digit entered therefore ends up in the MSBs.
  - The cycle that accepts digit DIGITS goes to WAIT_ROM.
  - `LogOutPulse`=1 goes to IDLE; this abort takes priority over a simultaneous `EnterPswd` and does not count as a failure.
- **WAIT_ROM:** wait exactly ROM_LAT cycles, then go to COMPARE.
- **COMPARE:** sample `RomData`. A match requires the entry register to equal `RomData` and the latched ID to be < NUM_USERS. An out-of-range ID always fails.
  - Match: clear the fail counter and go to PASSED.
  - Mismatch: pulse `FailPulse` and increment the fail counter. If the counter reaches MAX_FAILS, clear it, load the lock counter, and go to LOCKED. Otherwise go to IDLE.
- **PASSED:** `Authenticated`=1. `LogOutPulse`=1 goes to IDLE; `BeginCheck` is ignored.
- **LOCKED:** `LockedOut`=1 for exactly LOCK_CYCLES cycles, then go to IDLE. All inputs are ignored.
- `BeginCheck` outside IDLE is ignored. `EnterPswd` outside GET_DIG is ignored, including on the BeginCheck cycle.
- The fail counter is global and counts consecutive failures. It is cleared only by a success, by entering LOCKED, or by reset.

## Timing
- Reset values: all outputs 0, `RomAddr`=0, state IDLE, and all counters and registers 0. Reset overrides any state mid-operation.
- `BeginCheck` sampled at edge t: GET_DIG from t+1, `RomAddr` valid from t+1.
- Last digit sampled at edge k:
  - WAIT_ROM during cycles k+1 .. k+ROM_LAT.
  - COMPARE at k+ROM_LAT+1.
  - On a match, `Authenticated`=1 from k+ROM_LAT+2.
  - On a mismatch, `FailPulse`=1 for the single cycle k+ROM_LAT+2.
- `LockedOut` rises in the same cycle as `FailPulse` and stays high for LOCK_CYCLES cycles.
- `Authenticated` falls in the cycle after `LogOutPulse` is sampled.
- `DigitCount` updates one cycle after each accepted strobe and returns to 0 on entry to IDLE.

## Test plan
- **Correct login:** defaults, ROM[2]=0xEEE420, ID=2, digits E,E,E,4,2,0 → `Authenticated`=1 exactly 4 cycles after the last strobe. Then `LogOutPulse` → `Authenticated`=0 the next cycle.
- **Wrong password:** ID=2, digits E,E,E,4,2,1 → one `FailPulse`, state IDLE, `Authenticated` stays 0.
- **Lockout:** MAX_FAILS=3, LOCK_CYCLES=16, three wrong checks → `LockedOut` high for 16 cycles, and a `BeginCheck` issued during that window is ignored. A correct check afterwards passes.
- **Out-of-range ID:** ID=9 with NUM_USERS=8, and ROM[9] matching the entered password → `FailPulse`, no pass.
- **Abort:** after 3 digits, `LogOutPulse` together with `EnterPswd` → IDLE, `DigitCount`=0, fail counter unchanged, `FailPulse` stays low.
- **Parameter sweep:** DIGITS=8, DIG_W=4, ROM_LAT=1, ROM[0]=0xA54E3200 → pass 3 cycles after the 8th strobe. Also assert `Reset` mid-GET_DIG → all outputs 0 the next cycle.

Source files
------------

// File: rtl/pswd_auth_ctrl.sv
// pswd_auth_ctrl: multi-user password authentication controller.
// Collects DIGITS keyed digits for a claimed user ID, compares them against
// that user's word from an external synchronous ROM, holds Authenticated
// until logout, and locks the controller out after MAX_FAILS consecutive
// failed checks.
module pswd_auth_ctrl #(
    parameter int NUM_USERS   = 8,
    parameter int ID_W        = 5,
    parameter int DIGITS      = 6,
    parameter int DIG_W       = 4,
    parameter int ROM_LAT     = 2,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           BeginCheck,
    input  logic [ID_W-1:0]                InternalID,
    input  logic                           EnterPswd,
    input  logic [DIG_W-1:0]               InputSwitches,
    input  logic                           LogOutPulse,
    output logic [ID_W-1:0]                RomAddr,
    input  logic [DIGITS*DIG_W-1:0]        RomData,
    output logic                           Authenticated,
    output logic                           FailPulse,
    output logic                           LockedOut,
    output logic [$clog2(DIGITS+1)-1:0]    DigitCount
);

    localparam int ENTRY_W = DIGITS * DIG_W;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int WAIT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(DIGITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ROM_LAT - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES);
    // One extra bit so NUM_USERS == 2**ID_W is still representable.
    localparam logic [ID_W:0]     USER_LIMIT = (ID_W + 1)'(NUM_USERS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DIG  = 3'd1,
        ST_WAIT_ROM = 3'd2,
        ST_COMPARE  = 3'd3,
        ST_PASSED   = 3'd4,
        ST_LOCKED   = 3'd5
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     id_r;
    logic [ENTRY_W-1:0]  entry_r;
    logic [CNT_W-1:0]    digit_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [FAIL_W-1:0]   fail_cnt_r;
    logic [LOCK_W-1:0]   lock_cnt_r;
    logic                auth_r;
    logic                fail_pulse_r;
    logic                locked_r;
    logic                match_s;

    // An out-of-range ID can never match, whatever the ROM returns for it.
    assign match_s = (entry_r == RomData) && ({1'b0, id_r} < USER_LIMIT);

    // The latched ID doubles as the ROM address so the read is stable
    // for the whole check.
    assign RomAddr       = id_r;
    assign Authenticated = auth_r;
    assign FailPulse     = fail_pulse_r;
    assign LockedOut     = locked_r;
    assign DigitCount    = digit_cnt_r;

    // Session FSM with its counters and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            id_r         <= '0;
            entry_r      <= '0;
            digit_cnt_r  <= '0;
            wait_cnt_r   <= '0;
            fail_cnt_r   <= '0;
            lock_cnt_r   <= '0;
            auth_r       <= 1'b0;
            fail_pulse_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            fail_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    entry_r     <= '0;
                    digit_cnt_r <= '0;
                    wait_cnt_r  <= '0;
                    if (BeginCheck) begin
                        id_r    <= InternalID;
                        state_r <= ST_GET_DIG;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GET_DIG: begin
                    // Abort wins over a digit strobe in the same cycle.
                    if (LogOutPulse) begin
                        digit_cnt_r <= '0;
                        state_r     <= ST_IDLE;
                    end else if (EnterPswd) begin
                        entry_r     <= (entry_r << DIG_W) | ENTRY_W'(InputSwitches);
                        digit_cnt_r <= digit_cnt_r + CNT_W'(1);
                        if (digit_cnt_r == LAST_DIGIT) begin
                            state_r <= ST_WAIT_ROM;
                        end else begin
                            state_r <= ST_GET_DIG;
                        end
                    end else begin
                        state_r <= ST_GET_DIG;
                    end
                end
                ST_WAIT_ROM: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= ST_COMPARE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (match_s) begin
                        fail_cnt_r <= '0;
                        auth_r     <= 1'b1;
                        state_r    <= ST_PASSED;
                    end else begin
                        fail_pulse_r <= 1'b1;
                        if (fail_cnt_r == FAIL_LAST) begin
                            fail_cnt_r <= '0;
                            lock_cnt_r <= LOCK_LOAD;
                            locked_r   <= 1'b1;
                            state_r    <= ST_LOCKED;
                        end else begin
                            fail_cnt_r  <= fail_cnt_r + FAIL_W'(1);
                            digit_cnt_r <= '0;
                            state_r     <= ST_IDLE;
                        end
                    end
                end
                ST_PASSED: begin
                    if (LogOutPulse) begin
                        auth_r      <= 1'b0;
                        digit_cnt_r <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_PASSED;
                    end
                end
                ST_LOCKED: begin
                    // Counter holds the number of locked cycles still to run,
                    // including the current one.
                    if (lock_cnt_r == LOCK_W'(1)) begin
                        locked_r    <= 1'b0;
                        digit_cnt_r <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
                    end
                end
                default: begin
                    auth_r   <= 1'b0;
                    locked_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
